// File: rtl/apb_req_bridge.sv
// Valid/ready request channel to APB master bridge, one transaction in flight.
// Optional ACCESS-phase timeout is enabled by defining APB_TIMEOUT_EN.
//
// state  | meaning
// IDLE   | ready for a request, no bus activity
// SETUP  | APB setup phase, psel=1 penable=0
// ACCESS | APB access phase, waiting for pready
// RESP   | response held on rsp_* until rsp_ready
module apb_req_bridge #(
  parameter int ADDR_W         = 32,
  parameter int DATA_W         = 32,
  parameter int TIMEOUT_CYCLES = 256
) (
  input  logic              clk,
  input  logic              rst_n,
  input  logic              req_valid,
  output logic              req_ready,
  input  logic              req_write,
  input  logic [ADDR_W-1:0] req_addr,
  input  logic [DATA_W-1:0] req_wdata,
  output logic              rsp_valid,
  input  logic              rsp_ready,
  output logic [DATA_W-1:0] rsp_rdata,
  output logic              rsp_err,
  output logic              busy,
  output logic [ADDR_W-1:0] paddr,
  output logic              psel,
  output logic              penable,
  output logic              pwrite,
  output logic [DATA_W-1:0] pwdata,
  input  logic              pready,
  input  logic [DATA_W-1:0] prdata,
  input  logic              pslverr
);

  typedef enum logic [1:0] {IDLE, SETUP, ACCESS, RESP} stateT;

  stateT state, stateNxt;
  logic  rdyEn;
  logic  accept;
  logic  misaligned;
  logic  timeoutHit;

  assign accept     = req_valid && req_ready;
  assign misaligned = (req_addr[1:0] != 2'b00);

`ifdef APB_TIMEOUT_EN
  localparam int CW = $clog2(TIMEOUT_CYCLES + 1);
  logic [CW-1:0] waitCnt;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      waitCnt <= '0;
    end else if (state == SETUP) begin
      waitCnt <= '0;
    end else if (state == ACCESS && !pready) begin
      waitCnt <= waitCnt + CW'(1);
    end
  end

  assign timeoutHit = (state == ACCESS) && !pready && (waitCnt == CW'(TIMEOUT_CYCLES - 1));
`else
  assign timeoutHit = 1'b0;
`endif

  // rdyEn keeps req_ready low until the first edge after reset release
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state <= IDLE;
      rdyEn <= 1'b0;
    end else begin
      state <= stateNxt;
      rdyEn <= 1'b1;
    end
  end

  always_comb begin
    stateNxt = state;
    case (state)
      IDLE:    if (accept) stateNxt = misaligned ? RESP : SETUP;
      SETUP:   stateNxt = ACCESS;
      ACCESS:  if (pready || timeoutHit) stateNxt = RESP;
      RESP:    if (rsp_ready) stateNxt = IDLE;
      default: stateNxt = IDLE;
    endcase
  end

  always_comb begin
    req_ready = (state == IDLE) && rdyEn;
    psel      = (state == SETUP) || (state == ACCESS);
    penable   = (state == ACCESS);
    rsp_valid = (state == RESP);
    busy      = (state != IDLE);
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      paddr     <= '0;
      pwrite    <= 1'b0;
      pwdata    <= '0;
      rsp_rdata <= '0;
      rsp_err   <= 1'b0;
    end else begin
      if (accept) begin
        paddr  <= req_addr;
        pwrite <= req_write;
        pwdata <= req_write ? req_wdata : '0;
        if (misaligned) begin
          rsp_err   <= 1'b1;
          rsp_rdata <= '0;
        end
      end
      if (state == ACCESS) begin
        if (pready) begin
          rsp_err   <= pslverr;
          rsp_rdata <= (pwrite || pslverr) ? '0 : prdata;
        end else if (timeoutHit) begin
          rsp_err   <= 1'b1;
          rsp_rdata <= '0;
        end
      end
    end
  end

endmodule

// File: tb/tb_apb_req_bridge.sv
// Self-checking bench for apb_req_bridge: directed plan cases plus random traffic.
// Timeout cases are compiled in when APB_TIMEOUT_EN is defined.
module tb_apb_req_bridge;

  localparam int TO = 8;
`ifdef APB_TIMEOUT_EN
  localparam bit TO_EN = 1'b1;
`else
  localparam bit TO_EN = 1'b0;
`endif

  logic        clk = 1'b0;
  logic        rst_n;
  logic        req_valid, req_ready, req_write;
  logic [31:0] req_addr, req_wdata;
  logic        rsp_valid, rsp_ready, rsp_err, busy;
  logic [31:0] rsp_rdata, paddr, pwdata, prdata;
  logic        psel, penable, pwrite, pready, pslverr;

  int checks = 0;
  int errors = 0;

  apb_req_bridge #(.ADDR_W(32), .DATA_W(32), .TIMEOUT_CYCLES(TO)) dut (
    .clk(clk), .rst_n(rst_n),
    .req_valid(req_valid), .req_ready(req_ready), .req_write(req_write),
    .req_addr(req_addr), .req_wdata(req_wdata),
    .rsp_valid(rsp_valid), .rsp_ready(rsp_ready), .rsp_rdata(rsp_rdata),
    .rsp_err(rsp_err), .busy(busy),
    .paddr(paddr), .psel(psel), .penable(penable), .pwrite(pwrite),
    .pwdata(pwdata), .pready(pready), .prdata(prdata), .pslverr(pslverr)
  );

  always #5 clk = ~clk;

  task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  // Expected response derives from the request and slave behaviour only:
  // misaligned, timed out, or slave error -> err with zero data; writes return zero.
  task automatic txn(input logic wr, input logic [31:0] addr, input logic [31:0] wd,
                     input int waits, input logic [31:0] rd, input logic se,
                     input int hold, input bit holdReq);
    bit          mis, timedOut, expErr;
    logic [31:0] expRd;
    int          accCycles;
    mis       = (addr[1:0] != 2'b00);
    timedOut  = TO_EN && !mis && (waits >= TO);
    accCycles = timedOut ? TO : waits + 1;
    expErr    = mis || timedOut || se;
    expRd     = (expErr || wr) ? 32'h0 : rd;

    chk("idle_req_ready", req_ready, 1);
    chk("idle_busy", busy, 0);
    req_valid = 1'b1; req_write = wr; req_addr = addr; req_wdata = wd;
    @(posedge clk); @(negedge clk);
    req_valid = 1'b0; req_write = 1'($urandom); req_addr = $urandom; req_wdata = $urandom;

    if (!mis) begin
      chk("setup_psel", psel, 1);
      chk("setup_penable", penable, 0);
      chk("setup_paddr", paddr, addr);
      chk("setup_pwrite", pwrite, wr);
      chk("setup_pwdata", pwdata, wr ? wd : 32'h0);
      chk("setup_rsp_valid", rsp_valid, 0);
      chk("setup_req_ready", req_ready, 0);
      pready = 1'($urandom); prdata = $urandom; pslverr = 1'($urandom);
      for (int k = 0; k < accCycles; k++) begin
        @(posedge clk); @(negedge clk);
        chk("access_psel", psel, 1);
        chk("access_penable", penable, 1);
        chk("access_paddr", paddr, addr);
        chk("access_pwdata", pwdata, wr ? wd : 32'h0);
        chk("access_rsp_valid", rsp_valid, 0);
        pready  = (k == waits);
        prdata  = (k == waits) ? rd : $urandom;
        pslverr = (k == waits) ? se : 1'($urandom);
      end
      @(posedge clk); @(negedge clk);
      pready = 1'b0; pslverr = 1'b0;
    end

    req_valid = holdReq;
    for (int h = 0; h <= hold; h++) begin
      chk("resp_valid", rsp_valid, 1);
      chk("resp_err", rsp_err, expErr);
      chk("resp_rdata", rsp_rdata, expRd);
      chk("resp_psel", psel, 0);
      chk("resp_penable", penable, 0);
      chk("resp_req_ready", req_ready, 0);
      chk("resp_busy", busy, 1);
      rsp_ready = (h == hold);
      @(posedge clk); @(negedge clk);
    end
    rsp_ready = 1'b0; req_valid = 1'b0;
    chk("post_rsp_valid", rsp_valid, 0);
    chk("post_busy", busy, 0);
    chk("post_req_ready", req_ready, 1);
  endtask

  initial begin
    rst_n = 1'b0; req_valid = 1'b0; req_write = 1'b0; req_addr = '0; req_wdata = '0;
    rsp_ready = 1'b0; pready = 1'b0; prdata = '0; pslverr = 1'b0;
    repeat (3) @(negedge clk);
    chk("rst_req_ready", req_ready, 0);
    chk("rst_rsp_valid", rsp_valid, 0);
    chk("rst_psel", psel, 0);
    chk("rst_penable", penable, 0);
    chk("rst_busy", busy, 0);
    chk("rst_paddr", paddr, 0);
    chk("rst_pwdata", pwdata, 0);
    chk("rst_pwrite", pwrite, 0);
    chk("rst_rsp_rdata", rsp_rdata, 0);
    chk("rst_rsp_err", rsp_err, 0);
    rst_n = 1'b1;
    @(posedge clk); @(negedge clk);

    // zero-wait write, 3-wait read, slave-error read, misaligned write
    txn(1'b1, 32'h0000_1004, 32'hDEAD_BEEF, 0, 32'h0, 1'b0, 0, 1'b0);
    txn(1'b0, 32'h0000_2008, 32'h0, 3, 32'h1234_5678, 1'b0, 0, 1'b0);
    txn(1'b0, 32'h0000_300C, 32'h0, 1, 32'hFFFF_FFFF, 1'b1, 0, 1'b0);
    txn(1'b1, 32'h0000_0003, 32'h5555_AAAA, 0, 32'h0, 1'b0, 0, 1'b0);
    // response back-pressure with a pending request held high
    txn(1'b0, 32'h0000_0040, 32'h0, 0, 32'hCAFE_F00D, 1'b0, 5, 1'b1);
    txn(1'b1, 32'h0000_0044, 32'h0BAD_0BAD, 2, 32'h0, 1'b0, 0, 1'b0);

`ifdef APB_TIMEOUT_EN
    txn(1'b0, 32'h0000_0100, 32'h0, 1000, 32'h1111_2222, 1'b0, 0, 1'b0);
    txn(1'b0, 32'h0000_0104, 32'h0, TO - 1, 32'h3333_4444, 1'b0, 0, 1'b0);
`endif

    // reset in the middle of ACCESS
    req_valid = 1'b1; req_write = 1'b0; req_addr = 32'h0000_0200;
    @(posedge clk); @(negedge clk);
    req_valid = 1'b0;
    @(posedge clk); @(negedge clk);
    chk("pre_rst_penable", penable, 1);
    #2 rst_n = 1'b0;
    #1;
    chk("midrst_psel", psel, 0);
    chk("midrst_penable", penable, 0);
    chk("midrst_rsp_valid", rsp_valid, 0);
    chk("midrst_req_ready", req_ready, 0);
    chk("midrst_busy", busy, 0);
    @(negedge clk);
    rst_n = 1'b1; pready = 1'b1;
    for (int i = 0; i < 3; i++) begin
      @(posedge clk); @(negedge clk);
      chk("postrst_rsp_valid", rsp_valid, 0);
      chk("postrst_psel", psel, 0);
      chk("postrst_req_ready", req_ready, 1);
    end
    pready = 1'b0;

    for (int n = 0; n < 30; n++) begin
      logic [31:0] a;
      a = $urandom;
      a[1:0] = ($urandom_range(0, 3) == 0) ? 2'($urandom_range(1, 3)) : 2'b00;
      txn(1'($urandom), a, $urandom, $urandom_range(0, 4), $urandom,
          ($urandom_range(0, 4) == 0), $urandom_range(0, 2), 1'b0);
    end

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule

// File: doc/apb_req_bridge.md
Name: apb_req_bridge

Overview:
Converts a valid/ready request channel from the block's command source into APB master transactions. Responses return on a valid/ready response channel. Sits directly upstream of apbDecode and drives its apbReg (apb_if.dst) port. One transaction is in flight at a time. The block guarantees APB-legal SETUP/ACCESS sequencing and rejects misaligned addresses locally, without issuing them on the bus.

Parameters:
ADDR_W, 32, request/APB address width (matches apbAddrSt)
DATA_W, 32, request/APB data width (matches apbDataSt)
TIMEOUT_CYCLES, 256, ACCESS-phase cycle limit when APB_TIMEOUT_EN is defined; legal range >= 2

Ports:
clk  input  1  clock, all state on rising edge
rst_n  input  1  asynchronous active-low reset
req_valid  input  1  request valid
req_ready  output  1  request accepted when req_valid && req_ready
req_write  input  1  1 = write, 0 = read
req_addr  input  ADDR_W  byte address
req_wdata  input  DATA_W  write data
rsp_valid  output  1  response valid
rsp_ready  input  1  response consumed when rsp_valid && rsp_ready
rsp_rdata  output  DATA_W  read data; 0 for writes and errors
rsp_err  output  1  pslverr, misalignment, or timeout
busy  output  1  high in any state other than IDLE
paddr  output  ADDR_W  APB address
psel  output  1  APB select
penable  output  1  APB enable
pwrite  output  1  APB direction
pwdata  output  DATA_W  APB write data
pready  input  1  APB ready
prdata  input  DATA_W  APB read data
pslverr  input  1  APB slave error

Behaviour:
- Reset (asynchronous, rst_n=0): state=IDLE. Every output is 0 except req_ready, which is also 0 while rst_n=0. An in-flight transaction is dropped and no response is produced. After deassertion, req_ready=1 on the first clock edge.
- FSM states:
  - IDLE: req_ready=1. On accept, capture req_write, req_addr, req_wdata.
    - req_addr[1:0] != 0 -> RESP with rsp_err=1, rsp_rdata=0. No APB activity.
    - Otherwise -> SETUP.
  - SETUP: psel=1, penable=0; paddr/pwrite/pwdata driven from captured values. Always -> ACCESS next cycle. pready in SETUP is ignored.
  - ACCESS: psel=1, penable=1; address/data/direction held stable. Stays in ACCESS while pready=0. On pready=1:
    - rsp_rdata = prdata for reads, 0 for writes.
    - rsp_err = pslverr; on error, rsp_rdata=0.
    - -> RESP.
  - RESP: psel=penable=0. rsp_valid=1 with rsp_rdata/rsp_err stable until rsp_ready=1, then -> IDLE. rsp_ready=1 arriving in the same cycle rsp_valid rises completes in that cycle.
- req_ready is 1 only in IDLE. No new request is accepted in the RESP cycle.
- pwdata=0 for reads. paddr/pwrite/pwdata hold their last value in IDLE/RESP; the bench must not check them there.
- Latency: accept at cycle T -> psel at T+1 -> penable at T+2. With zero wait states, pready at T+2 -> rsp_valid at T+3. Minimum 4 cycles per transaction with rsp_ready tied high. A misaligned request gives rsp_valid at T+1.
- rsp_valid and psel are never high in the same cycle.
- busy = (state != IDLE).

Optional Feature:
Macro APB_TIMEOUT_EN.
- Defined:
  - A counter of width $clog2(TIMEOUT_CYCLES+1) clears on entry to ACCESS and increments each ACCESS cycle with pready=0.
  - When the count reaches TIMEOUT_CYCLES-1 with pready still 0, the next state is RESP with rsp_err=1 and rsp_rdata=0. psel/penable drop in the RESP cycle.
  - pready=1 on the final counted cycle wins: normal completion.
- Not defined: no counter; ACCESS waits indefinitely for pready.

Test Plan:
- Write addr 0x0000_1004, data 0xDEAD_BEEF, pready=1 immediately -> psel T+1, penable T+2, pwrite=1, pwdata=0xDEADBEEF; rsp_valid T+3, rsp_err=0, rsp_rdata=0.
- Read addr 0x0000_2008, pready after 3 wait cycles, prdata=0x1234_5678 -> penable held 4 cycles with paddr stable; rsp_rdata=0x12345678, rsp_err=0.
- Read with pslverr=1, prdata=0xFFFF_FFFF -> rsp_err=1, rsp_rdata=0. Write addr 0x0000_0003 -> psel never asserted, rsp_valid at T+1, rsp_err=1.
- Hold rsp_ready=0 for 5 cycles after response, with req_valid held high -> rsp_valid/data stable, req_ready=0 throughout. A second request is accepted only on the cycle after the rsp handshake.
- rst_n pulled low mid-ACCESS -> psel/penable/rsp_valid/req_ready drop to 0 immediately with no edge required. After release, IDLE, no spurious response.
- APB_TIMEOUT_EN, TIMEOUT_CYCLES=8, pready never asserted -> penable high exactly 8 cycles, then rsp_err=1, rsp_rdata=0. Repeat with pready on the 8th ACCESS cycle -> rsp_err=0.
